// File: rtl/axi_line_writeback.sv
// Writes one 32-byte cache line per request as an 8-beat AXI3 INCR burst and tracks outstanding B responses.
// Optional macro AXI_LINE_WB_AW_W_OVERLAP_EN lets W beats start alongside the AW request.
module axi_line_writeback #(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AXI_ID          = 4'd1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         line_req,
    output logic         line_ack,
    input  logic [26:0]  line_paddr,
    input  logic [255:0] line_data,
    output logic         busy,
    output logic         idle_all,
    output logic         bresp_err,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [3:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic [1:0]   awlock,
    output logic [3:0]   awcache,
    output logic [2:0]   awprot,
    output logic         awvalid,
    input  logic         awready,
    output logic [3:0]   wid,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W} state_t;

    state_t        state;
    logic [2:0]    word_idx;
    logic [3:0]    outstanding;
    logic [26:0]   paddr_reg;
    logic [255:0]  line_reg;
    logic          aw_hs;
    logic          w_hs;
    logic          wlast_hs;
    logic          b_hs;
    logic          burst_done;
    logic          unused_bid;

    assign unused_bid = ^bid;

    assign line_ack = (state == S_IDLE) && line_req && (outstanding < 4'(MAX_OUTSTANDING));

    assign awid    = AXI_ID;
    assign awaddr  = {paddr_reg, 5'b0};
    assign awlen   = 4'd7;
    assign awsize  = 3'd2;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = (state == S_AW);

    assign wid   = AXI_ID;
    assign wdata = line_reg[{word_idx, 5'b0} +: 32];
    assign wstrb = 4'hF;
    assign wlast = (word_idx == 3'd7);

    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign wlast_hs = w_hs && wlast;
    assign b_hs     = bvalid && bready;

`ifdef AXI_LINE_WB_AW_W_OVERLAP_EN
    // S_AW means the address is still pending; w_done remembers a W stream that finished first.
    logic w_done;

    assign wvalid     = ((state == S_AW) || (state == S_W)) && !w_done;
    assign burst_done = ((state == S_AW) && aw_hs && (w_done || wlast_hs)) ||
                        ((state == S_W) && wlast_hs);
`else
    assign wvalid     = (state == S_W);
    assign burst_done = wlast_hs;
`endif

    // The completing wlast beat already counts as outstanding for B acceptance.
    assign bready   = (outstanding != 4'd0) || burst_done;
    assign busy     = (state != S_IDLE) || (outstanding != 4'd0);
    assign idle_all = !busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            word_idx    <= 3'd0;
            outstanding <= 4'd0;
            bresp_err   <= 1'b0;
            paddr_reg   <= 27'd0;
            line_reg    <= 256'd0;
`ifdef AXI_LINE_WB_AW_W_OVERLAP_EN
            w_done      <= 1'b0;
`endif
        end else begin
            if (burst_done && !b_hs) begin
                outstanding <= outstanding + 4'd1;
            end else if (!burst_done && b_hs) begin
                outstanding <= outstanding - 4'd1;
            end
            if (b_hs && (bresp != 2'b00)) begin
                bresp_err <= 1'b1;
            end
            if (w_hs) begin
                word_idx <= word_idx + 3'd1;
            end
            case (state)
                S_IDLE: begin
                    if (line_ack) begin
                        paddr_reg <= line_paddr;
                        line_reg  <= line_data;
                        state     <= S_AW;
`ifdef AXI_LINE_WB_AW_W_OVERLAP_EN
                        word_idx  <= 3'd0;
                        w_done    <= 1'b0;
`endif
                    end
                end
                S_AW: begin
`ifdef AXI_LINE_WB_AW_W_OVERLAP_EN
                    if (wlast_hs) begin
                        w_done <= 1'b1;
                    end
                    if (aw_hs) begin
                        state <= (w_done || wlast_hs) ? S_IDLE : S_W;
                    end
`else
                    if (aw_hs) begin
                        word_idx <= 3'd0;
                        state    <= S_W;
                    end
`endif
                end
                S_W: begin
                    if (wlast_hs) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_line_writeback.sv
// Bench for axi_line_writeback: directed scenarios plus randomized AXI slave behaviour,
// checked every cycle against a transaction-level model of lines, beats and outstanding responses.
module tb_axi_line_writeback;

    localparam int MAX = 2;
    localparam logic [3:0] ID = 4'd1;

    logic         clk = 1'b0;
    logic         rst;
    logic         line_req;
    logic         line_ack;
    logic [26:0]  line_paddr;
    logic [255:0] line_data;
    logic         busy, idle_all, bresp_err;
    logic [3:0]   awid, awlen, awcache, wid, wstrb, bid;
    logic [31:0]  awaddr, wdata;
    logic [2:0]   awsize, awprot;
    logic [1:0]   awburst, awlock, bresp;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    axi_line_writeback #(.MAX_OUTSTANDING(MAX), .AXI_ID(ID)) dut (
        .clk(clk), .rst(rst),
        .line_req(line_req), .line_ack(line_ack), .line_paddr(line_paddr), .line_data(line_data),
        .busy(busy), .idle_all(idle_all), .bresp_err(bresp_err),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model: lines in flight, beat count of the current burst, outstanding responses.
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    int  m_out = 0;
    int  m_beat = 0;
    bit  m_in_burst = 0;
    bit  m_aw_done = 0;
    bit  m_err = 0;
    int  ack_cnt = 0, wl_cnt = 0, ack_cyc = 0, wl_cyc = 0;
    logic [31:0] last_awaddr = 0;
    logic [31:0] last_awlen = 0;
    bit  slave_rand = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        exp_addr_q.delete();
        m_out = 0; m_beat = 0; m_in_burst = 0; m_aw_done = 0; m_err = 0;
        ack_cnt = 0; wl_cnt = 0;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (slave_rand) begin
            #1;
            awready = 1'($urandom_range(0, 1));
            wready  = ($urandom_range(0, 3) != 0);
            bvalid  = 1'($urandom_range(0, 1));
            bresp   = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            bid     = 4'($urandom_range(0, 15));
        end
    end

    // Per-cycle scoreboard: compares all outputs with the model, then applies this cycle's handshakes.
    always @(negedge clk) begin : monitor
        bit inc, dec, busy_e, ack_e, b_e;
        if (!rst) begin
            busy_e = m_in_burst || (m_out != 0);
            ack_e  = line_req && !m_in_burst && (m_out < MAX);
            b_e    = (m_out != 0) || (m_in_burst && m_aw_done && wready && (m_beat == 7));
            check("busy", 32'(busy), 32'(busy_e));
            check("idle_all", 32'(idle_all), 32'(!busy_e));
            check("bresp_err", 32'(bresp_err), 32'(m_err));
            check("line_ack", 32'(line_ack), 32'(ack_e));
            check("bready", 32'(bready), 32'(b_e));
            check("awvalid", 32'(awvalid), 32'(m_in_burst && !m_aw_done));
            check("wvalid", 32'(wvalid), 32'(m_in_burst && m_aw_done));
            inc = 0;
            dec = 0;
            if (awvalid) begin
                check("awaddr", awaddr, (exp_addr_q.size() != 0) ? exp_addr_q[0] : 32'hDEAD_BEEF);
                check("awlen", 32'(awlen), 32'd7);
                check("awsize", 32'(awsize), 32'd2);
                check("awburst", 32'(awburst), 32'd1);
                check("awid", 32'(awid), 32'(ID));
                check("aw_lock_cache_prot", 32'({awlock, awcache, awprot}), 32'd0);
                if (awready) begin
                    if (exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
                    m_aw_done = 1;
                    m_beat = 0;
                    last_awaddr = awaddr;
                    last_awlen = 32'(awlen);
                end
            end
            if (wvalid && wready) begin
                if (exp_q.size() != 0) check("wdata", wdata, exp_q.pop_front());
                else check("wdata_unexpected", wdata, 32'hDEAD_BEEF);
                check("wlast", 32'(wlast), 32'(m_beat == 7));
                check("wstrb", 32'(wstrb), 32'hF);
                check("wid", 32'(wid), 32'(ID));
                m_beat++;
                if (m_beat == 8) begin
                    inc = 1;
                    m_in_burst = 0;
                    m_aw_done = 0;
                    wl_cnt++;
                    wl_cyc = cyc;
                end
            end
            if (bvalid && bready) begin
                dec = 1;
                if (bresp != 2'b00) m_err = 1;
            end
            m_out = m_out + int'(inc) - int'(dec);
            if (line_ack) begin
                exp_addr_q.push_back({line_paddr, 5'b0});
                for (int j = 0; j < 8; j++) exp_q.push_back(line_data[32*j +: 32]);
                m_in_burst = 1;
                m_aw_done = 0;
                ack_cnt++;
                ack_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input logic [26:0] pa, input logic [255:0] d);
        int k;
        tick();
        line_paddr = pa;
        line_data = d;
        line_req = 1'b1;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (line_ack) break;
        end
        check("ack_seen", 32'(k < 300), 32'd1);
        tick();
        line_req = 1'b0;
        line_paddr = 27'($urandom);
        line_data = rand_line();
    endtask

    task automatic wait_wl(input int target);
        for (int k = 0; k < 300 && wl_cnt < target; k++) @(negedge clk);
        check("wlast_count", 32'(wl_cnt), 32'(target));
    endtask

    task automatic wait_idle(input logic [1:0] resp);
        int k;
        tick();
        bvalid = 1'b1;
        bresp = resp;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (idle_all) break;
        end
        check("drain_idle", 32'(k < 300), 32'd1);
        tick();
        bvalid = 1'b0;
        bresp = 2'b00;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog time limit reached");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : stim
        logic [255:0] d;
        int base;
        int k;
        rst = 1'b1;
        line_req = 1'b0; line_paddr = '0; line_data = '0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = 2'b00; bvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_idle_all", 32'(idle_all), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_awvalid", 32'(awvalid), 32'd0);
        check("rst_wvalid", 32'(wvalid), 32'd0);
        check("rst_err", 32'(bresp_err), 32'd0);

        // Single line with addresses and data from the test plan
        for (int j = 0; j < 8; j++) d[32*j +: 32] = 32'hA0 + 32'(j);
        awready = 1'b1; wready = 1'b1;
        send_line(27'h0000123, d);
        wait_wl(1);
        check("single_awaddr", last_awaddr, 32'h0000_2460);
        check("single_awlen", last_awlen, 32'd7);
        check("single_ack_to_wlast", 32'(wl_cyc - ack_cyc), 32'd9);
        wait_idle(2'b00);
        check("single_idle", 32'(idle_all), 32'd1);
        check("single_err", 32'(bresp_err), 32'd0);

        // Backpressure: AW stalled 5 more cycles, then wready toggling
        awready = 1'b0; wready = 1'b0;
        send_line(27'($urandom), rand_line());
        repeat (5) tick();
        awready = 1'b1;
        wready = 1'b1;
        for (k = 0; k < 60 && wl_cnt < 2; k++) begin
            tick();
            wready = ~wready;
        end
        wait_wl(2);
        wait_idle(2'b00);

        // Outstanding limit with B held off
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
        base = wl_cnt;
        send_line(27'($urandom), rand_line());
        send_line(27'($urandom), rand_line());
        line_paddr = 27'($urandom);
        line_data = rand_line();
        line_req = 1'b1;
        wait_wl(base + 2);
        repeat (3) begin
            @(negedge clk);
            check("limit_hold", 32'(line_ack), 32'd0);
        end
        tick();
        bvalid = 1'b1;
        @(negedge clk);
        check("limit_b_cycle", 32'(line_ack), 32'd0);
        tick();
        bvalid = 1'b0;
        @(negedge clk);
        check("limit_ack_next", 32'(line_ack), 32'd1);
        tick();
        line_req = 1'b0;
        wait_wl(base + 3);
        wait_idle(2'b00);

        // B handshake coinciding with wlast while one response is outstanding
        base = wl_cnt;
        send_line(27'($urandom), rand_line());
        wait_wl(base + 1);
        send_line(27'($urandom), rand_line());
        for (k = 0; k < 40; k++) begin
            tick();
            if (wvalid && wlast) break;
        end
        check("sim_wlast_seen", 32'(k < 40), 32'd1);
        bvalid = 1'b1;
        @(negedge clk);
        check("sim_bready", 32'(bready), 32'd1);
        tick();
        bvalid = 1'b0;
        @(negedge clk);
        check("sim_busy", 32'(busy), 32'd1);
        check("sim_still_one", 32'(bready), 32'd1);
        wait_idle(2'b00);

        // Sticky error on the second burst
        base = wl_cnt;
        send_line(27'($urandom), rand_line());
        wait_wl(base + 1);
        wait_idle(2'b00);
        check("err_before", 32'(bresp_err), 32'd0);
        send_line(27'($urandom), rand_line());
        wait_wl(base + 2);
        wait_idle(2'b10);
        check("err_set", 32'(bresp_err), 32'd1);
        send_line(27'($urandom), rand_line());
        wait_wl(base + 3);
        wait_idle(2'b00);
        check("err_sticky", 32'(bresp_err), 32'd1);

        // Asynchronous reset in the middle of the W burst
        send_line(27'($urandom), rand_line());
        for (k = 0; k < 40; k++) begin
            tick();
            if (m_aw_done && m_beat == 3) break;
        end
        check("arst_beat3_reached", 32'(k < 40), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_awvalid", 32'(awvalid), 32'd0);
        check("arst_wvalid", 32'(wvalid), 32'd0);
        check("arst_idle_all", 32'(idle_all), 32'd1);
        check("arst_err_clr", 32'(bresp_err), 32'd0);
        reset_model();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        send_line(27'($urandom), rand_line());
        wait_wl(1);
        wait_idle(2'b00);

        // Randomized slave timing and random lines
        slave_rand = 1;
        for (int i = 0; i < 25; i++) send_line(27'($urandom), rand_line());
        for (k = 0; k < 3000 && wl_cnt < ack_cnt; k++) @(negedge clk);
        check("rand_all_written", 32'(wl_cnt), 32'(ack_cnt));
        @(negedge clk);
        slave_rand = 0;
        @(posedge clk);
        #2;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        wait_idle(2'b00);
        check("final_idle", 32'(idle_all), 32'd1);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_line_writeback.md
Name: axi_line_writeback

Overview:
- Downstream stage of the data-cache write buffer: accepts one 32-byte dirty line (8 × 32-bit words) per request.
- Issues that line as a single AXI3 INCR burst: AW handshake, 8 W beats, then B response.
- Tracks outstanding B responses so the write buffer can tell when all its drained lines are globally complete (needed before its clear-done).

Parameters:
- MAX_OUTSTANDING, 2: maximum number of bursts whose last W beat has completed but whose B response has not yet arrived; range 1..15.
- AXI_ID, 4'd1: constant value driven on awid and wid.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- line_req  in  1  line write request; held with paddr/data until line_ack
- line_ack  out  1  one-cycle pulse: line captured
- line_paddr  in  27  physical address bits [31:5]
- line_data  in  256  word i = bits [32i+31:32i]; word 0 is sent first
- busy  out  1  burst in progress, or any B response outstanding
- idle_all  out  1  no burst in progress and outstanding count == 0
- bresp_err  out  1  sticky: set by a B response with bresp != 0; cleared only by rst
- awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid  out  4, 32, 4, 3, 2, 2, 4, 3, 1  AXI AW channel
- awready  in  1
- wid, wdata, wstrb, wlast, wvalid  out  4, 32, 4, 1, 1  AXI W channel
- wready  in  1
- bid  in  4
- bresp  in  2
- bvalid  in  1
- bready  out  1

Behaviour:
- Reset (async assert):
  - state = S_IDLE, word_idx = 0, outstanding = 0, bresp_err = 0.
  - All valid outputs and line_ack = 0; busy = 0; idle_all = 1.
  - Any burst in flight is abandoned with no completion.
- States: S_IDLE, S_AW, S_W.
- S_IDLE:
  - If line_req && outstanding < MAX_OUTSTANDING, pulse line_ack the same cycle (combinational).
  - Capture paddr and the 8 words into registers, then go to S_AW.
  - Otherwise stay in S_IDLE; line_ack = 0.
- S_AW:
  - awvalid = 1; awaddr = {paddr_reg, 5'b0}.
  - Fixed fields: awlen = 7, awsize = 2, awburst = 2'b01, awlock = 0, awcache = 0, awprot = 0.
  - All AW fields stay stable until awready.
  - On awvalid && awready: word_idx <= 0, go to S_W.
- S_W:
  - wvalid = 1; wdata = word[word_idx]; wstrb = 4'hF; wlast = (word_idx == 7).
  - Each wready advances word_idx by 1.
  - On the beat with wlast && wready: outstanding increments, go to S_IDLE.
  - No bubble between beats when wready is held high: exactly 8 cycles in S_W.
- B channel:
  - bready = 1 whenever outstanding != 0 or a wlast handshake is occurring this cycle; otherwise 0.
  - Each bvalid && bready decrements outstanding.
  - A wlast handshake and a B handshake in the same cycle leave outstanding unchanged.
  - bid is not checked.
  - A B handshake with outstanding == 0 cannot occur, because bready is low then.
- Derived outputs:
  - busy = (state != S_IDLE) || (outstanding != 0).
  - idle_all = !busy.
- Latency:
  - line_ack to awvalid: 1 cycle.
  - Minimum request-to-wlast: 10 cycles with awready and wready held high.
- Back-to-back: a new line_req can be acknowledged in the cycle the FSM re-enters S_IDLE if outstanding < MAX_OUTSTANDING. Otherwise it stalls until a B response arrives.
- Captured data is independent of line_data after line_ack; the upstream side may change inputs immediately.

Optional Feature:
- Macro: AXI_LINE_WB_AW_W_OVERLAP_EN.
- Defined:
  - From S_AW, wvalid is also asserted with word 0 in the same cycle as awvalid.
  - Separate aw_done and W progress flags are kept; beats are accepted before, with, or after the AW handshake.
  - Return to S_IDLE (and increment outstanding) happens once both the AW handshake and the wlast handshake are done.
  - Minimum request-to-wlast: 9 cycles.
- Undefined: wvalid is never asserted before the AW handshake completes (behaviour above).

Test Plan:
- Single line: paddr = 27'h0000123, words 0..7 = 32'hA0..A7, awready/wready/bvalid high one cycle after wlast.
  - Expect awaddr = 32'h00002460 and awlen = 7.
  - Expect 8 beats A0..A7, wlast on beat 7.
  - idle_all returns to 1 after B; bresp_err = 0.
- Backpressure: awready low for 5 cycles, then wready toggling 1,0,1,0…
  - AW fields are stable while stalled.
  - Exactly 8 beats in order; word_idx never skips.
- Outstanding limit, MAX_OUTSTANDING = 2, bvalid held low:
  - Three back-to-back requests; the first two are acked.
  - The third is not acked until bvalid = 1 for one cycle, then acked the next cycle.
- Simultaneous: a B handshake coincides with the wlast handshake while outstanding = 1 → outstanding stays 1; busy stays 1.
- Error: bresp = 2'b10 on the second burst → bresp_err rises and stays 1 through later OKAY responses until rst.
- Async reset asserted mid-S_W at beat 3, between clock edges:
  - Outputs drop immediately: awvalid = wvalid = 0, idle_all = 1.
  - After deassert, a new request bursts from word 0.
